// File: rtl/regfile_write_arbiter_pkg.sv
// Shared LC-3b types for the register-file write arbiter and its aux write queue.
package regfile_write_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef struct packed {
    logic     valid;
    lc3b_reg  dest;
    lc3b_word data;
  } lc3b_rf_wr_t;

  localparam int unsigned RF_REGS = 8;

  // One-hot register select used to build pending-write masks.
  function automatic logic [RF_REGS-1:0] reg_onehot(input lc3b_reg r);
    reg_onehot = 8'h01 << r;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rf_wr_fifo.sv
// Aux write queue: DEPTH entries with per-entry kill bits, kill-by-destination
// and a mask of destinations still owed a write by live entries.
module rf_wr_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  lc3b_rf_wr_t        push_entry,
  input  logic               pop,
  input  logic               kill_en,
  input  lc3b_reg            kill_dest,
  output lc3b_rf_wr_t        head_entry,
  output logic               head_killed,
  output logic               full,
  output logic               empty,
  output logic [RF_REGS-1:0] dest_mask
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The payload valid bit doubles as slot occupancy.
  lc3b_rf_wr_t            mem_r [DEPTH];
  logic [DEPTH-1:0]       kill_r;
  logic [PTR_W-1:0]       head_r;
  logic [PTR_W-1:0]       tail_r;

  // Occupancy flags, head view and live-destination mask.
  always_comb begin
    full      = 1'b1;
    empty     = 1'b1;
    dest_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_r[i].valid) begin
        empty = 1'b0;
        if (!kill_r[i]) begin
          dest_mask = dest_mask | reg_onehot(mem_r[i].dest);
        end else begin
          dest_mask = dest_mask;
        end
      end else begin
        full = 1'b0;
      end
    end
    head_entry  = mem_r[head_r];
    head_killed = mem_r[head_r].valid & kill_r[head_r];
  end

  // Queue storage: kill marking applies only to entries present before this cycle's push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      kill_r <= '0;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem_r[i].valid && (mem_r[i].dest == kill_dest)) begin
          kill_r[i] <= 1'b1;
        end
      end
      if (pop) begin
        mem_r[head_r].valid <= 1'b0;
        head_r              <= head_r + PTR_W'(1);
      end
      if (push) begin
        mem_r[tail_r]  <= push_entry;
        kill_r[tail_r] <= 1'b0;
        tail_r         <= tail_r + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB (priority) and a queued aux
// requester, with a starvation guard and a pending-write mask for decode.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  input  lc3b_reg             wb_dest,
  input  lc3b_word            wb_data,
  output logic                wb_ready,
  input  logic                aux_valid,
  input  lc3b_reg             aux_dest,
  input  lc3b_word            aux_data,
  output logic                aux_ready,
  output logic                rf_load,
  output lc3b_reg             rf_dest,
  output lc3b_word            rf_data,
  output logic [RF_REGS-1:0]  pend_mask
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]   wait_cnt_r;
  lc3b_rf_wr_t        head_entry_s;
  lc3b_rf_wr_t        push_entry_s;
  logic               head_killed_s;
  logic               full_s;
  logic               empty_s;
  logic [RF_REGS-1:0] dest_mask_s;
  logic               head_live_s;
  logic               starve_s;
  logic               head_grant_s;
  logic               wb_grant_s;
  logic               push_s;
  logic               pop_s;

  assign head_live_s  = head_entry_s.valid & ~head_killed_s;
  assign starve_s     = head_live_s & (wait_cnt_r == CNT_W'(MAX_WAIT));
  assign push_entry_s = '{valid: 1'b1, dest: aux_dest, data: aux_data};

  // Grant selection and port outputs; everything is held quiet while in reset.
  always_comb begin
    head_grant_s = 1'b0;
    wb_grant_s   = 1'b0;
    wb_ready     = 1'b0;
    aux_ready    = 1'b0;
    pend_mask    = '0;
    rf_load      = 1'b0;
    rf_dest      = '0;
    rf_data      = '0;
    if (reset) begin
      wb_ready = 1'b0;
    end else begin
      aux_ready = ~full_s;
      pend_mask = dest_mask_s;
      if (starve_s) begin
        head_grant_s = 1'b1;
        wb_ready     = 1'b0;
      end else if (wb_valid) begin
        wb_grant_s = 1'b1;
        wb_ready   = 1'b1;
      end else if (head_live_s) begin
        head_grant_s = 1'b1;
        wb_ready     = 1'b1;
      end else begin
        wb_ready = 1'b1;
      end
    end
    if (head_grant_s) begin
      rf_load = 1'b1;
      rf_dest = head_entry_s.dest;
      rf_data = head_entry_s.data;
    end else if (wb_grant_s) begin
      rf_load = 1'b1;
      rf_dest = wb_dest;
      rf_data = wb_data;
    end else begin
      rf_load = 1'b0;
    end
  end

  // A killed head leaves without using the port, so it may pop alongside a WB write.
  assign pop_s  = ~reset & (head_grant_s | head_killed_s);
  assign push_s = aux_valid & aux_ready;

  // Counts consecutive cycles a live head is denied the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (pop_s || empty_s) begin
      wait_cnt_r <= '0;
    end else if (head_live_s && (wait_cnt_r != CNT_W'(MAX_WAIT))) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push_s),
    .push_entry  (push_entry_s),
    .pop         (pop_s),
    .kill_en     (wb_grant_s),
    .kill_dest   (wb_dest),
    .head_entry  (head_entry_s),
    .head_killed (head_killed_s),
    .full        (full_s),
    .empty       (empty_s),
    .dest_mask   (dest_mask_s)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the arbiter.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        wb_ready;
  logic        aux_valid;
  logic [2:0]  aux_dest;
  logic [15:0] aux_data;
  logic        aux_ready;
  logic        rf_load;
  logic [2:0]  rf_dest;
  logic [15:0] rf_data;
  logic [7:0]  pend_mask;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ready(wb_ready),
    .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_data(aux_data), .aux_ready(aux_ready),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_data(rf_data), .pend_mask(pend_mask)
  );

  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
    bit          killed;
  } m_entry_t;

  typedef struct {
    logic        rf_load;
    logic [2:0]  rf_dest;
    logic [15:0] rf_data;
    logic        wb_ready;
    logic        aux_ready;
    logic [7:0]  pend_mask;
  } exp_t;

  m_entry_t    mq[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          losses = 0;
  logic [15:0] mdl_rf [8];
  logic [15:0] sh_rf  [8];
  int          vectors = 0;
  int          miscompares = 0;
  bit          prev_wb_stall = 1'b0;
  bit          prev_aux_stall = 1'b0;
  bit          t6_window = 1'b0;
  bit          t6_leak = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict that cycle's outputs, advance the model.
  task automatic step(input bit rst, input bit wv, input logic [2:0] wd, input logic [15:0] wdat,
                      input bit av, input logic [2:0] ad, input logic [15:0] adat);
    exp_t     e;
    m_entry_t ne;
    bit       was_empty, head_live, starve, head_wr, wb_wr, popped;
    if (!rst && prev_wb_stall) begin
      wv = 1'b1; wd = wb_dest; wdat = wb_data;
    end
    if (!rst && prev_aux_stall) begin
      av = 1'b1; ad = aux_dest; adat = aux_data;
    end
    reset = rst; wb_valid = wv; wb_dest = wd; wb_data = wdat;
    aux_valid = av; aux_dest = ad; aux_data = adat;

    e = '{rf_load: 1'b0, rf_dest: 3'd0, rf_data: 16'h0000, wb_ready: 1'b0,
          aux_ready: 1'b0, pend_mask: 8'h00};
    if (rst) begin
      mq.delete();
      losses = 0;
    end else begin
      was_empty = (mq.size() == 0);
      head_live = !was_empty && !mq[0].killed;
      starve    = head_live && (losses == MAX_WAIT);
      foreach (mq[i]) if (!mq[i].killed) e.pend_mask[mq[i].dest] = 1'b1;
      e.aux_ready = (mq.size() < DEPTH);
      e.wb_ready  = !starve;
      head_wr = starve || (!wv && head_live);
      wb_wr   = !starve && wv;
      if (head_wr) begin
        e.rf_load = 1'b1; e.rf_dest = mq[0].dest; e.rf_data = mq[0].data;
      end else if (wb_wr) begin
        e.rf_load = 1'b1; e.rf_dest = wd; e.rf_data = wdat;
      end
      if (e.rf_load) mdl_rf[e.rf_dest] = e.rf_data;
      popped = head_wr || (!was_empty && mq[0].killed);
      if (wb_wr) foreach (mq[i]) if (mq[i].dest == wd) mq[i].killed = 1'b1;
      if (popped) void'(mq.pop_front());
      if (popped || was_empty) losses = 0;
      else if (head_live && losses < MAX_WAIT) losses++;
      if (av && e.aux_ready) begin
        ne.dest = ad; ne.data = adat; ne.killed = 1'b0;
        mq.push_back(ne);
      end
    end
    exp_q.push_back(e);
    prev_wb_stall  = !rst && wv && !e.wb_ready;
    prev_aux_stall = !rst && av && !e.aux_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
  endtask

  // Monitor: tracks regfile writes and compares each cycle against the prediction.
  always @(negedge clk) begin
    if (rf_load === 1'b1) begin
      sh_rf[rf_dest] = rf_data;
      if (t6_window && rf_data[15:8] == 8'hC0) t6_leak = 1'b1;
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rf_load", 32'(rf_load), 32'(mon_e.rf_load));
      check("rf_dest", 32'(rf_dest), 32'(mon_e.rf_dest));
      check("rf_data", 32'(rf_data), 32'(mon_e.rf_data));
      check("wb_ready", 32'(wb_ready), 32'(mon_e.wb_ready));
      check("aux_ready", 32'(aux_ready), 32'(mon_e.aux_ready));
      check("pend_mask", 32'(pend_mask), 32'(mon_e.pend_mask));
    end
  end

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_dest = 3'd0; wb_data = 16'h0000;
    aux_valid = 1'b0; aux_dest = 3'd0; aux_data = 16'h0000;
    for (int r = 0; r < 8; r++) begin
      mdl_rf[r] = 16'h0000; sh_rf[r] = 16'h0000;
    end
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 3'd1, 16'h5555, 1'b1, 3'd2, 16'h6666);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);

    // WB only
    step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000);
    // Aux only
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hBEEF);
    idle(2);
    check("t2_r5", 32'(sh_rf[5]), 32'h0000BEEF);

    // Contention and starvation: WB held high on R4 while R1 waits
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h1111);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'd4, 16'h4000 + 16'(k), 1'b0, 3'd0, 16'h0000);
    idle(1);
    check("t3_r1", 32'(sh_rf[1]), 32'h00001111);

    // Kill: newer WB value to R2 supersedes queued aux value
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0001);
    step(1'b0, 1'b1, 3'd2, 16'h0002, 1'b0, 3'd0, 16'h0000);
    idle(3);
    check("t4_r2", 32'(sh_rf[2]), 32'h00000002);

    // Full FIFO, stalled third push, then steady push/pop with pointer wrap
    step(1'b0, 1'b1, 3'd6, 16'h6000, 1'b1, 3'd0, 16'hA000);
    step(1'b0, 1'b1, 3'd6, 16'h6001, 1'b1, 3'd7, 16'hA001);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'd6, 16'h6002 + 16'(k), 1'b1, 3'd3, 16'hA002);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, k[2:0], 16'hB000 + 16'(k));
    idle(3);

    // Reset with two entries queued
    t6_window = 1'b1;
    step(1'b0, 1'b1, 3'd6, 16'h6100, 1'b1, 3'd1, 16'hC001);
    step(1'b0, 1'b1, 3'd6, 16'h6101, 1'b1, 3'd2, 16'hC002);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hC003);
    idle(4);
    t6_window = 1'b0;
    check("t6_leak", 32'(t6_leak), 32'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), 16'($urandom));
    end
    idle(8);

    repeat (4) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    for (int r = 0; r < 8; r++) check("final_rf", 32'(sh_rf[r]), 32'(mdl_rf[r]));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
